// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
// Receives a servo PWM signal, measures its high time and rising-to-rising
// period in clock cycles and decodes the high time into an angle (0..180 deg)
// with a sequential restoring divider. One angle_valid strobe per period.
// Optional build macro: GLITCH_FILTER_EN (4-sample level filter after the
// synchronizer; pulses shorter than 4 cycles are ignored).

module servo_pwm_decoder #(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned MIN_PULSE_US = 1000,
   parameter int unsigned MAX_PULSE_US = 2000,
   parameter int unsigned PERIOD_US    = 20000,
   parameter int unsigned CNT_W        = 23,
   parameter int unsigned ANGLE_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pwm_in,
   output logic [ANGLE_W-1:0] angle_out,
   output logic               angle_valid,
   output logic [CNT_W-1:0]   width_cnt,
   output logic [CNT_W-1:0]   period_cnt,
   output logic               err_range,
   output logic               err_timeout
);

   // Cycle counts derived from the time parameters (64-bit to avoid overflow)
   localparam longint unsigned CYC_MIN_L = (64'(CLK_FREQ_HZ) * 64'(MIN_PULSE_US)) / 64'd1_000_000;
   localparam longint unsigned CYC_MAX_L = (64'(CLK_FREQ_HZ) * 64'(MAX_PULSE_US)) / 64'd1_000_000;
   localparam longint unsigned CYC_PER_L = (64'(CLK_FREQ_HZ) * 64'(PERIOD_US)) / 64'd1_000_000;
   localparam longint unsigned CYC_TO_L  = 64'd2 * CYC_PER_L;

   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(CYC_MIN_L);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CYC_MAX_L);
   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(CYC_TO_L);
   localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

   // Numerator holds (clamped_hi - MIN_CNT) * 180; divider register holds
   // SPAN_CNT pre-shifted to the quotient MSB position.
   localparam int unsigned NUM_W  = CNT_W + 8;
   localparam int unsigned DIV_W  = NUM_W + ANGLE_W;
   localparam int unsigned STEP_W = $clog2(ANGLE_W) + 1;
   localparam logic [NUM_W-1:0]  DEG_FULL  = NUM_W'(32'd180);
   localparam logic [DIV_W-1:0]  DIV_INIT  = DIV_W'(CYC_MAX_L - CYC_MIN_L) << (ANGLE_W - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ANGLE_W - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(32'd1);

   // Level-tracking FSM
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_LOW   = 2'd2;
   // Angle computation engine, runs alongside the level tracker
   localparam logic [1:0] CS_IDLE  = 2'd0;
   localparam logic [1:0] CS_SETUP = 2'd1;
   localparam logic [1:0] CS_DIV   = 2'd2;

   logic               sync1_q, sync2_q, prev_q;
   logic               lvl_s, rise_s, fall_s;

   logic [1:0]         st_q, st_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   hi_lat_q, hi_lat_d;
   logic [1:0]         calc_st_q, calc_st_d;
   logic [CNT_W-1:0]   calc_hi_q, calc_hi_d;
   logic [CNT_W-1:0]   calc_per_q, calc_per_d;
   logic               rng_q, rng_d;
   logic [DIV_W-1:0]   rem_q, rem_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [ANGLE_W-1:0] quo_q, quo_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   width_q, width_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               err_rng_q, err_rng_d;
   logic               err_to_q, err_to_d;

   logic [CNT_W-1:0]   hic_s, diff_s;
   logic               oor_s;
   logic [NUM_W-1:0]   num_s;
   logic               ge_s;
   logic [DIV_W-1:0]   rem_sub_s;
   logic [ANGLE_W-1:0] quo_next_s;
   logic [CNT_W-1:0]   cnt_inc_s;

   // Saturating increment: counters stick at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_ALL) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   // Two-flop synchronizer plus previous-level flop for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         sync2_q <= sync1_q;
         prev_q  <= lvl_s;
      end
   end

`ifdef GLITCH_FILTER_EN
   logic       filt_q, filt_d;
   logic [1:0] fcnt_q, fcnt_d;

   // Accept a new level on the 4th consecutive sample that differs from the current one
   always_comb begin
      filt_d = filt_q;
      fcnt_d = 2'd0;
      if (sync2_q != filt_q) begin
         if (fcnt_q == 2'd3) begin
            filt_d = sync2_q;
            fcnt_d = 2'd0;
         end else begin
            fcnt_d = fcnt_q + 2'd1;
         end
      end else begin
         fcnt_d = 2'd0;
      end
   end

   // Glitch filter state
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         fcnt_q <= 2'd0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   // filt_d shows the accepted level in the same cycle as the 4th sample
   assign lvl_s = filt_d;
`else
   assign lvl_s = sync2_q;
`endif

   assign rise_s = lvl_s & ~prev_q;
   assign fall_s = ~lvl_s & prev_q;

   // Clamp the captured high time into the decodable window and flag overrange
   always_comb begin
      if (calc_hi_q < MIN_CNT) begin
         hic_s = MIN_CNT;
         oor_s = 1'b1;
      end else if (calc_hi_q > MAX_CNT) begin
         hic_s = MAX_CNT;
         oor_s = 1'b1;
      end else begin
         hic_s = calc_hi_q;
         oor_s = 1'b0;
      end
   end

   assign diff_s     = hic_s - MIN_CNT;
   assign num_s      = {8'd0, diff_s} * DEG_FULL;
   assign ge_s       = (rem_q >= div_q);
   assign rem_sub_s  = rem_q - div_q;
   assign quo_next_s = {quo_q[ANGLE_W-2:0], ge_s};
   assign cnt_inc_s  = sat_inc(cnt_q);

   // Next-state logic: angle engine first, level tracker may start/abort it
   always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      hi_lat_d   = hi_lat_q;
      calc_st_d  = calc_st_q;
      calc_hi_d  = calc_hi_q;
      calc_per_d = calc_per_q;
      rng_d      = rng_q;
      rem_d      = rem_q;
      div_d      = div_q;
      quo_d      = quo_q;
      step_d     = step_q;
      angle_d    = angle_q;
      valid_d    = 1'b0;
      width_d    = width_q;
      period_d   = period_q;
      err_rng_d  = err_rng_q;
      err_to_d   = err_to_q;

      case (calc_st_q)
         CS_IDLE: begin
            calc_st_d = CS_IDLE;
         end
         CS_SETUP: begin
            rem_d     = {{ANGLE_W{1'b0}}, num_s};
            div_d     = DIV_INIT;
            quo_d     = {ANGLE_W{1'b0}};
            step_d    = {STEP_W{1'b0}};
            rng_d     = oor_s;
            calc_st_d = CS_DIV;
         end
         CS_DIV: begin
            if (ge_s) begin
               rem_d = rem_sub_s;
            end else begin
               rem_d = rem_q;
            end
            quo_d  = quo_next_s;
            div_d  = div_q >> 1;
            step_d = step_q + STEP_ONE;
            if (step_q == STEP_LAST) begin
               angle_d   = quo_next_s;
               width_d   = calc_hi_q;
               period_d  = calc_per_q;
               err_rng_d = rng_q;
               valid_d   = 1'b1;
               calc_st_d = CS_IDLE;
            end else begin
               calc_st_d = CS_DIV;
            end
         end
         default: begin
            calc_st_d = CS_IDLE;
         end
      endcase

      case (st_q)
         ST_IDLE: begin
            if (rise_s) begin
               st_d     = ST_HIGH;
               cnt_d    = CNT_ONE;
               err_to_d = 1'b0;
            end else begin
               st_d = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (cnt_q >= TO_CNT) begin
               st_d      = ST_IDLE;
               err_to_d  = 1'b1;
               calc_st_d = CS_IDLE;
               valid_d   = 1'b0;
            end else if (fall_s) begin
               hi_lat_d = cnt_q;
               cnt_d    = cnt_inc_s;
               st_d     = ST_LOW;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_LOW: begin
            if (cnt_q >= TO_CNT) begin
               st_d      = ST_IDLE;
               err_to_d  = 1'b1;
               calc_st_d = CS_IDLE;
               valid_d   = 1'b0;
            end else if (rise_s) begin
               calc_hi_d  = hi_lat_q;
               calc_per_d = cnt_q;
               calc_st_d  = CS_SETUP;
               cnt_d      = CNT_ONE;
               st_d       = ST_HIGH;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         hi_lat_q   <= {CNT_W{1'b0}};
         calc_st_q  <= CS_IDLE;
         calc_hi_q  <= {CNT_W{1'b0}};
         calc_per_q <= {CNT_W{1'b0}};
         rng_q      <= 1'b0;
         rem_q      <= {DIV_W{1'b0}};
         div_q      <= {DIV_W{1'b0}};
         quo_q      <= {ANGLE_W{1'b0}};
         step_q     <= {STEP_W{1'b0}};
         angle_q    <= {ANGLE_W{1'b0}};
         valid_q    <= 1'b0;
         width_q    <= {CNT_W{1'b0}};
         period_q   <= {CNT_W{1'b0}};
         err_rng_q  <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         hi_lat_q   <= hi_lat_d;
         calc_st_q  <= calc_st_d;
         calc_hi_q  <= calc_hi_d;
         calc_per_q <= calc_per_d;
         rng_q      <= rng_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         quo_q      <= quo_d;
         step_q     <= step_d;
         angle_q    <= angle_d;
         valid_q    <= valid_d;
         width_q    <= width_d;
         period_q   <= period_d;
         err_rng_q  <= err_rng_d;
         err_to_q   <= err_to_d;
      end
   end

   assign angle_out   = angle_q;
   assign angle_valid = valid_q;
   assign width_cnt   = width_q;
   assign period_cnt  = period_q;
   assign err_range   = err_rng_q;
   assign err_timeout = err_to_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder
// Drives PWM periods (directed and $urandom) into servo_pwm_decoder with a
// scaled-down clock parameter so a 20 ms period is 2000 cycles, and checks
// strobes, angles, widths, periods and error flags against a reference model.

module tb_servo_pwm_decoder;
   localparam int unsigned CLK_HZ  = 100_000;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned ANGLE_W = 8;

   localparam int MIN_W  = int'((64'(CLK_HZ) * 64'd1000) / 64'd1_000_000);
   localparam int MAX_W  = int'((64'(CLK_HZ) * 64'd2000) / 64'd1_000_000);
   localparam int PER_W  = int'((64'(CLK_HZ) * 64'd20000) / 64'd1_000_000);
   localparam int TO_W   = 2 * PER_W;
`ifdef GLITCH_FILTER_EN
   localparam int FILT_LAT = 3;
   localparam bit FILTER   = 1'b1;
`else
   localparam int FILT_LAT = 0;
   localparam bit FILTER   = 1'b0;
`endif
   // posedges from driving a rise (at a negedge) to the strobe being visible
   localparam int LAT = 2 + ANGLE_W + 2 + FILT_LAT;

   logic               clk = 1'b0;
   logic               rst;
   logic               pwm_in;
   logic [ANGLE_W-1:0] angle_out;
   logic               angle_valid;
   logic [CNT_W-1:0]   width_cnt;
   logic [CNT_W-1:0]   period_cnt;
   logic               err_range;
   logic               err_timeout;

   int checks  = 0;
   int errors  = 0;
   int strobes = 0;

   // reference model state
   bit have_prev  = 1'b0;
   int pend_w     = 0;
   int pend_p     = 0;
   int last_angle = 0;

   servo_pwm_decoder #(
      .CLK_FREQ_HZ (CLK_HZ),
      .MIN_PULSE_US(1000),
      .MAX_PULSE_US(2000),
      .PERIOD_US   (20000),
      .CNT_W       (CNT_W),
      .ANGLE_W     (ANGLE_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .angle_out  (angle_out),
      .angle_valid(angle_valid),
      .width_cnt  (width_cnt),
      .period_cnt (period_cnt),
      .err_range  (err_range),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (angle_valid === 1'b1) strobes++;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // angle in whole degrees: linear map of MIN..MAX cycles onto 0..180, floored
   function automatic int model_angle(input int w);
      if (w <= MIN_W) return 0;
      if (w >= MAX_W) return 180;
      return ((w - MIN_W) * 180) / (MAX_W - MIN_W);
   endfunction

   function automatic bit model_range(input int w);
      return (w < MIN_W) || (w > MAX_W);
   endfunction

   // One PWM period: h cycles high then l cycles low. rst_at>0 pulses rst
   // (with pwm forced low) after that many posedges.
   task automatic drive_period(input int h, input int l, input int rst_at);
      int s0;
      bit glitch;
      bit exp;
      bit did_rst;
      int ew;
      int ep;
      glitch  = FILTER && (h < 4);
      exp     = have_prev && !glitch && !((rst_at > 0) && (rst_at <= LAT));
      ew      = pend_w;
      ep      = pend_p;
      did_rst = 1'b0;
      @(negedge clk);
      s0     = strobes;
      pwm_in = 1'b1;
      for (int i = 1; i <= h + l; i++) begin
         @(posedge clk);
         #1;
         if (i == LAT - 1) check("no_early_strobe", angle_valid, 0);
         if (i == LAT) begin
            if (exp) begin
               check("strobe", angle_valid, 1);
               check("angle", angle_out, model_angle(ew));
               check("width", width_cnt, ew);
               check("period", period_cnt, ep);
               check("err_range", err_range, model_range(ew));
               last_angle = model_angle(ew);
            end else begin
               check("no_strobe", angle_valid, 0);
            end
            check("err_timeout_clear", err_timeout, 0);
         end
         if (i == TO_W - 8) check("timeout_not_yet", err_timeout, 0);
         if (i == TO_W + 12) check("timeout_set", err_timeout, 1);
         if (i == rst_at) begin
            @(negedge clk);
            rst    = 1'b1;
            pwm_in = 1'b0;
            @(posedge clk);
            #1;
            check("rst_angle", angle_out, 0);
            check("rst_valid", angle_valid, 0);
            check("rst_width", width_cnt, 0);
            check("rst_period", period_cnt, 0);
            check("rst_errs", {err_range, err_timeout}, 0);
            @(negedge clk);
            rst        = 1'b0;
            did_rst    = 1'b1;
            last_angle = 0;
         end
         if (i == h) begin
            @(negedge clk);
            pwm_in = 1'b0;
         end
      end
      check("strobe_count", strobes - s0, exp ? 1 : 0);
      if (did_rst) begin
         have_prev = 1'b0;
      end else if (glitch) begin
         pend_p = pend_p + h + l;
      end else if (h + l > TO_W + 2) begin
         have_prev = 1'b0;
      end else begin
         have_prev = 1'b1;
         pend_w    = h;
         pend_p    = h + l;
      end
      check("angle_hold", angle_out, last_angle);
   endtask

   initial begin
      int wl[6];
      wl = '{100, 200, 125, 50, 250, 150};
      pwm_in = 1'b0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_angle", angle_out, 0);
      check("reset_valid", angle_valid, 0);
      check("reset_width", width_cnt, 0);
      check("reset_period", period_cnt, 0);
      check("reset_err_range", err_range, 0);
      check("reset_err_timeout", err_timeout, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1.5 ms / 20 ms, three periods: first rise only arms
      repeat (3) drive_period(150, 1850, 0);
      check("nominal_strobes", strobes, 2);
      check("nominal_angle", angle_out, 90);
      check("nominal_period", period_cnt, PER_W);

      // boundary widths: 0, 180, 45, underrange, overrange, recovery to 90
      foreach (wl[k]) drive_period(wl[k], 600, 0);

      // randomized widths/periods, some outside the decodable window
      for (int n = 0; n < 12; n++) begin
         drive_period(int'($urandom_range(260, 60)), int'($urandom_range(1800, 200)), 0);
      end

      // stuck low beyond 2 periods, then resume
      drive_period(150, 4600, 0);
      check("timeout_level", err_timeout, 1);
      drive_period(150, 1850, 0);
      drive_period(150, 1850, 0);

      // reset while HIGH, then while the angle is being computed
      drive_period(120, 1000, 40);
      drive_period(150, 800, 0);
      drive_period(150, 800, 5);
      drive_period(175, 800, 0);
      drive_period(150, 600, 0);

      // 2-cycle high glitch inside the low phase
      drive_period(2, 900, 0);
      drive_period(150, 700, 0);
      drive_period(150, 700, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
